wishbone_arbiter: RTL

WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

---
 rtl/wishbone_arb_pkg.sv | 5 +
 rtl/wishbone_arbiter_rr.sv | 8 +
 rtl/wishbone_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/wishbone_arb_pkg.sv
// wishbone_arb_pkg: shared FSM state type and default timeout for wishbone_arbiter
package wishbone_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/wishbone_arbiter_rr.sv
// rr_arbiter: two-way round-robin grant; req[1:0] pending requests, last_grant = client served last, grant = winning index
module rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);
  always_comb grant = req[~last_grant] ? ~last_grant : last_grant;
endmodule

// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter: two-client round-robin front end for a wishbone_master; clients on req_*/rsp_*, master user side on m_*
module wishbone_arbiter
  import wishbone_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CLIENTS-1:0]   req_valid,
  input  logic [NUM_CLIENTS-1:0]   req_we,
  input  logic [8*NUM_CLIENTS-1:0] req_addr,
  input  logic [8*NUM_CLIENTS-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]   req_ready,
  output logic [NUM_CLIENTS-1:0]   rsp_valid,
  output logic [7:0]               rsp_rdata,
  output logic                     rsp_err,
  output logic                     m_burst_active,
  output logic                     m_write_en,
  output logic                     m_read_en,
  output logic [7:0]               m_write_addr,
  output logic [7:0]               m_write_data,
  output logic [7:0]               m_read_addr,
  input  logic                     m_write_ready,
  input  logic                     m_read_ready,
  input  logic [7:0]               m_read_data
);
  arb_state_t state, state_n;
  logic        last_grant, grant_c, grant_q, we_q, err_q;
  logic [7:0]  addr_q, wdata_q, rdata_q;
  logic [15:0] cnt, cnt_inc;
  logic        match, timeout, accept;
  rr_arbiter u_rr (.req(req_valid), .last_grant(last_grant), .grant(grant_c));
  assign cnt_inc = cnt + 16'd1;
  assign match   = we_q ? m_write_ready : m_read_ready;
  assign timeout = cnt_inc == 16'(TIMEOUT_CYCLES);
  // req_ready is combinational, so it is masked while rst holds the FSM in IDLE
  assign accept  = state == IDLE && |req_valid && !rst;
  assign m_burst_active = state == ISSUE || state == WAIT;
  assign m_write_en     = state == ISSUE && we_q;
  assign m_read_en      = state == ISSUE && !we_q;
  assign m_write_addr   = addr_q;
  assign m_read_addr    = addr_q;
  assign m_write_data   = wdata_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n   = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      IDLE:  if (accept) begin
        state_n = ISSUE;
        req_ready[grant_c] = 1'b1;
      end
      ISSUE: state_n = WAIT;
      WAIT:  state_n = match || timeout ? RESP : WAIT;
      RESP:  begin
        state_n = IDLE;
        rsp_valid[grant_q] = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        grant_q <= grant_c;
        we_q    <= req_we[grant_c];
        addr_q  <= req_addr[{grant_c, 3'b000} +: 8];
        wdata_q <= req_wdata[{grant_c, 3'b000} +: 8];
      end
      if (state == WAIT) begin
        cnt <= cnt_inc;
        // a matching ready beats a simultaneous timeout
        if (match) {rdata_q, err_q} <= {we_q ? 8'h00 : m_read_data, 1'b0};
        else if (timeout) {rdata_q, err_q} <= {8'h00, 1'b1};
      end
      if (state == RESP) begin
        last_grant <= grant_q;
        cnt        <= '0;
      end
    end
endmodule
